// File: rtl/mem_pkg.sv
// Shared constants, FSM state type and request payload for the MEM-stage data-memory access unit.
package mem_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } dmem_req_t;

    function automatic logic f3_is_store_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

    function automatic logic f3_is_load_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/halfword from a read word and sign- or zero-extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_data_c = '0;
        case (i_funct3)
            F3_B:    o_data_c = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data_c = {24'h000000, w_byte};
            F3_H:    o_data_c = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data_c = {16'h0000, w_half};
            F3_W:    o_data_c = i_rdata;
            default: o_data_c = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-RAM access: request generation, wait-state/timeout FSM and load formatting.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_valid_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [BE_W-1:0] dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_ready_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic [XLEN-1:0] Data_Load,
    output logic            stall_o,
    output logic            bus_err_o,
    output logic            misaligned_o
);

    mem_state_e       r_state;
    mem_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    logic             w_is_store;
    logic             w_is_load;
    logic             w_legal;
    logic             w_access;
    logic             w_mis;
    logic             w_go;
    logic             w_timeout;
    logic             w_req;
    logic [1:0]       w_off;
    dmem_req_t        w_dreq;
    logic [XLEN-1:0]  w_load_c;

    // A simultaneous read+write is treated as a store.
    assign w_is_store = mem_write_i;
    assign w_is_load  = mem_read_i & ~mem_write_i;
    assign w_legal    = w_is_store ? f3_is_store_legal(funct3_i)
                      : (w_is_load & f3_is_load_legal(funct3_i));
    assign w_access   = mem_valid_i & w_legal;

    // Halfwords drop addr[0], words drop addr[1:0]; the trap build flags those bits instead.
    always_comb begin
        w_off = addr_i[1:0];
        case (funct3_i[1:0])
            2'b01:   w_off = {addr_i[1], 1'b0};
            2'b10:   w_off = 2'b00;
            default: w_off = addr_i[1:0];
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_mis = w_access & (w_off != addr_i[1:0]);
`else
    assign w_mis = 1'b0;
`endif

    assign w_go      = w_access & ~w_mis;
    assign w_timeout = (r_state == ST_WAIT) && (r_count == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        w_dreq.we    = w_is_store;
        w_dreq.addr  = {addr_i[XLEN-1:2], 2'b00};
        w_dreq.be    = BE_W'(4'b1111);
        w_dreq.wdata = store_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                w_dreq.be    = BE_W'(4'b0001 << w_off);
                w_dreq.wdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                w_dreq.be    = BE_W'(4'b0011 << w_off);
                w_dreq.wdata = {2{store_data_i[15:0]}};
            end
            default: begin
                w_dreq.be    = BE_W'(4'b1111);
                w_dreq.wdata = store_data_i;
            end
        endcase
    end

    mem_load_align u_load_align (
        .i_rdata  (dmem_rdata_i),
        .i_off    (w_off),
        .i_funct3 (funct3_i),
        .o_data_c (w_load_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            ST_IDLE: begin
                w_count_nxt = '0;
                if (w_go && !dmem_ready_i) begin
                    w_state_nxt = ST_WAIT;
                    w_count_nxt = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (w_timeout || dmem_ready_i) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    // Combinational outputs; reset forces everything low, even mid-wait.
    always_comb begin
        w_req        = 1'b0;
        bus_err_o    = 1'b0;
        misaligned_o = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_IDLE: begin
                    w_req        = w_go;
                    misaligned_o = w_mis;
                end
                ST_WAIT: begin
                    w_req     = ~w_timeout;
                    bus_err_o = w_timeout;
                end
                default: w_req = 1'b0;
            endcase
        end
        dmem_req_o   = w_req;
        dmem_we_o    = w_req & w_dreq.we;
        dmem_addr_o  = w_req ? w_dreq.addr  : '0;
        dmem_be_o    = w_req ? w_dreq.be    : '0;
        dmem_wdata_o = w_req ? w_dreq.wdata : '0;
        stall_o      = w_req & ~dmem_ready_i;
        Data_Load    = (w_req && dmem_ready_i && w_is_load) ? w_load_c : '0;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, random model-checked traffic, timeout and reset sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid_i, mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, store_data_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ready_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] Data_Load;
    logic        stall_o, bus_err_o, misaligned_o;

    int    checks = 0;
    int    errors = 0;
    string tag = "init";

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk          (clk),
        .reset        (reset),
        .mem_valid_i  (mem_valid_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .store_data_i (store_data_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ready_i (dmem_ready_i),
        .dmem_rdata_i (dmem_rdata_i),
        .Data_Load    (Data_Load),
        .stall_o      (stall_o),
        .bus_err_o    (bus_err_o),
        .misaligned_o (misaligned_o)
    );

    typedef struct {
        logic        valid, rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, sdata, rdata;
        int          waits;
        logic        e_req, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wdata, e_load;
        logic        e_mis;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic valid, input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                                input int waits, input logic e_req, input logic e_we, input logic [3:0] e_be,
                                input logic [31:0] e_addr, input logic [31:0] e_wdata,
                                input logic [31:0] e_load, input logic e_mis);
        vec_t v;
        v.valid = valid; v.rd = rd; v.wr = wr; v.f3 = f3;
        v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.waits = waits;
        v.e_req = e_req; v.e_we = e_we; v.e_be = e_be; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_load = e_load; v.e_mis = e_mis;
        return v;
    endfunction

    // Reference model: derives the expected bus request and load value from access size arithmetic.
    function automatic vec_t model(input vec_t vin);
        vec_t   v = vin;
        logic   store = v.wr;
        logic   load  = v.rd & ~v.wr;
        logic   legal;
        logic   trap;
        int     bytes, off, off_eff;
        longint val;
        legal = v.valid && ((store && (v.f3 inside {3'd0, 3'd1, 3'd2})) ||
                            (load && (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})));
        bytes   = 1 << v.f3[1:0];
        off     = int'(v.addr[1:0]);
        off_eff = off - (off % bytes);
`ifdef MEM_MISALIGN_TRAP_EN
        trap = legal && (off != off_eff);
`else
        trap = 1'b0;
`endif
        v.e_mis  = trap;
        v.e_req  = legal && !trap;
        v.e_we   = store;
        v.e_addr = v.addr & 32'hFFFF_FFFC;
        v.e_be   = 4'(((1 << bytes) - 1) << off_eff);
        for (int i = 0; i < 4; i++)
            v.e_wdata[8*i +: 8] = v.sdata[8*(i % bytes) +: 8];
        v.e_load = '0;
        if (load && v.e_req) begin
            val = (longint'(v.rdata) >> (8 * off_eff)) & ((64'sd1 <<< (8 * bytes)) - 1);
            if (!v.f3[2] && bytes < 4 && val >= (64'sd1 <<< (8 * bytes - 1)))
                val = val - (64'sd1 <<< (8 * bytes));
            v.e_load = val[31:0];
        end
        return v;
    endfunction

    task automatic drive(input vec_t v);
        mem_valid_i  = v.valid;
        mem_read_i   = v.rd;
        mem_write_i  = v.wr;
        funct3_i     = v.f3;
        addr_i       = v.addr;
        store_data_i = v.sdata;
    endtask

    task automatic idle_inputs();
        mem_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        funct3_i = 3'd0; addr_i = '0; store_data_i = '0;
        dmem_ready_i = 1'b0; dmem_rdata_i = '0;
    endtask

    task automatic chk_all_zero();
        chk("req0", 32'(dmem_req_o), 32'd0);
        chk("stall0", 32'(stall_o), 32'd0);
        chk("berr0", 32'(bus_err_o), 32'd0);
        chk("mis0", 32'(misaligned_o), 32'd0);
        chk("load0", Data_Load, 32'd0);
        chk("we0", 32'(dmem_we_o), 32'd0);
        chk("be0", 32'(dmem_be_o), 32'd0);
    endtask

    // One transaction; ready rises in the cycle after the requested number of wait states.
    task automatic apply(input vec_t v);
        int ncyc;
        ncyc = v.e_req ? v.waits + 1 : 1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            drive(v);
            dmem_ready_i = (!v.e_req || k == v.waits);
            dmem_rdata_i = (dmem_ready_i) ? v.rdata : $urandom;
            #1;
            chk("req", 32'(dmem_req_o), 32'(v.e_req));
            chk("stall", 32'(stall_o), 32'(v.e_req && k < v.waits));
            chk("berr", 32'(bus_err_o), 32'd0);
            chk("mis", 32'(misaligned_o), 32'(v.e_mis));
            if (v.e_req) begin
                chk("we", 32'(dmem_we_o), 32'(v.e_we));
                chk("addr", dmem_addr_o, v.e_addr);
                chk("be", 32'(dmem_be_o), 32'(v.e_be));
                if (v.e_we) chk("wdata", dmem_wdata_o, v.e_wdata);
            end
            chk("load", Data_Load, (v.e_req && k == v.waits) ? v.e_load : 32'd0);
        end
    endtask

    vec_t tbl[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        idle_inputs();
        reset = 1'b1;

        tag = "reset";
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h100;
            dmem_ready_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
            #1;
            chk_all_zero();
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();

        //            vld rd wr f3      addr          sdata          rdata     wt req we be       eaddr         ewdata         eload        mis
        tbl[0]  = mk(1, 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 0, 4'b1111, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        tbl[1]  = mk(1, 1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 3, 1, 0, 4'b1000, 32'h100, 32'h0, 32'hFFFFFF80, 0);
        tbl[2]  = mk(1, 1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 3, 1, 0, 4'b1000, 32'h100, 32'h0, 32'h00000080, 0);
        tbl[3]  = mk(1, 0, 1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 0, 1, 1, 4'b1100, 32'h100, 32'hABCDABCD, 32'h0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        tbl[4]  = mk(1, 1, 0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 1);
`else
        tbl[4]  = mk(1, 1, 0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0, 1, 0, 4'b1111, 32'h100, 32'h0, 32'h12345678, 0);
`endif
        tbl[5]  = mk(1, 1, 0, 3'b001, 32'h202, 32'h0, 32'h80017FFF, 1, 1, 0, 4'b1100, 32'h200, 32'h0, 32'hFFFF8001, 0);
        tbl[6]  = mk(1, 1, 0, 3'b101, 32'h200, 32'h0, 32'h12348765, 2, 1, 0, 4'b0011, 32'h200, 32'h0, 32'h00008765, 0);
        tbl[7]  = mk(1, 0, 1, 3'b000, 32'h305, 32'h000000A5, 32'h0, 0, 1, 1, 4'b0010, 32'h304, 32'hA5A5A5A5, 32'h0, 0);
        tbl[8]  = mk(1, 1, 0, 3'b011, 32'h400, 32'h0, 32'hCAFEF00D, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 0);
        tbl[9]  = mk(1, 1, 1, 3'b010, 32'h500, 32'h01020304, 32'hCAFEF00D, 1, 1, 1, 4'b1111, 32'h500, 32'h01020304, 32'h0, 0);
        tbl[10] = mk(0, 1, 0, 3'b010, 32'h600, 32'h0, 32'hCAFEF00D, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 0);
        tbl[11] = mk(1, 1, 1, 3'b100, 32'h700, 32'h0, 32'h0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 0);
        tbl[12] = mk(1, 1, 0, 3'b000, 32'h702, 32'h0, 32'h00C50000, 0, 1, 0, 4'b0100, 32'h700, 32'h0, 32'hFFFFFFC5, 0);

        for (int i = 0; i < 13; i++) begin
            tag = $sformatf("tbl%0d", i);
            apply(tbl[i]);
        end

        tag = "ready_no_req";
        @(negedge clk);
        idle_inputs();
        dmem_ready_i = 1'b1; dmem_rdata_i = 32'h12345678;
        #1;
        chk_all_zero();

        tag = "timeout";
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            mem_valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0;
            funct3_i = 3'b010; addr_i = 32'h800;
            dmem_ready_i = (k == 16);
            dmem_rdata_i = 32'h55AA55AA;
            #1;
            chk($sformatf("req_c%0d", k), 32'(dmem_req_o), 32'(k < 16));
            chk($sformatf("stall_c%0d", k), 32'(stall_o), 32'(k < 16));
            chk($sformatf("berr_c%0d", k), 32'(bus_err_o), 32'(k == 16));
            if (k == 16) chk("load_abort", Data_Load, 32'd0);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk_all_zero();
        tag = "after_timeout";
        apply(mk(1, 1, 0, 3'b010, 32'h900, 32'h0, 32'h0BADF00D, 0, 1, 0, 4'b1111, 32'h900, 32'h0, 32'h0BADF00D, 0));

        tag = "reset_mid_wait";
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0;
            funct3_i = 3'b010; addr_i = 32'hA00; dmem_ready_i = 1'b0;
            reset = (k == 1);
            #1;
            if (k == 0) chk("stall_pre", 32'(stall_o), 32'd1);
            else        chk_all_zero();
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        chk_all_zero();
        tag = "sw_after_reset";
        apply(mk(1, 0, 1, 3'b010, 32'h300, 32'h11223344, 32'h0, 1, 1, 1, 4'b1111, 32'h300, 32'h11223344, 32'h0, 0));

        for (int n = 0; n < 60; n++) begin
            v.valid = ($urandom_range(0, 7) != 0);
            v.rd    = 1'($urandom);
            v.wr    = 1'($urandom);
            v.f3    = 3'($urandom_range(0, 7));
            v.addr  = $urandom;
            v.sdata = $urandom;
            v.rdata = $urandom;
            v.waits = $urandom_range(0, 4);
            v = model(v);
            tag = $sformatf("rnd%0d", n);
            apply(v);
        end

        @(negedge clk);
        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
